regfile_pipe: RTL and testbench
===============================

REGFILE_PIPE -- requirements
Module: regfile_pipe

Interface
REQ-001 SHALL have parameter ADDRESS_WIDTH, default 5, meaning register index width (2**ADDRESS_WIDTH registers).
REQ-002 SHALL have parameter DATA_WIDTH, default 32, meaning register width.
REQ-003 SHALL have parameter READ_PORTS, default 2, meaning the number of independent asynchronous read ports (range 1..4).
REQ-004 SHALL have parameter BYPASS, default 1, meaning write-to-read forwarding is enabled when 1.
REQ-005 SHALL have parameter A0_INDEX, default 10, meaning the register mirrored on a0.
REQ-006 SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-007 SHALL have port rst, input, 1, reset, synchronous and active-high.
REQ-008 SHALL have port ad, input, READ_PORTS*ADDRESS_WIDTH, packed read addresses; port i is bits [i*ADDRESS_WIDTH +: ADDRESS_WIDTH].
REQ-009 SHALL have port rd, output, READ_PORTS*DATA_WIDTH, packed read data, with the same slicing as ad.
REQ-010 SHALL have port busy, output, READ_PORTS, pending-write flag for each read port's address.
REQ-011 SHALL have port ad3, input, ADDRESS_WIDTH, write address.
REQ-012 SHALL have port wd3, input, DATA_WIDTH, write data.
REQ-013 SHALL have port we3, input, 1, write enable; a write also retires the scoreboard entry.
REQ-014 SHALL have port issue_valid, input, 1, marks issue_rd as having a pending producer.
REQ-015 SHALL have port issue_rd, input, ADDRESS_WIDTH, destination register being issued.
REQ-016 SHALL have port ready, output, 1, high once the power-on clear has completed.
REQ-017 SHALL have port a0, output, DATA_WIDTH, current value of register A0_INDEX.

Function
REQ-018 SHALL implement a two-state FSM: CLEAR and RUN.
REQ-019 In CLEAR, each cycle SHALL write zero to mem[cnt] and increment cnt.
REQ-020 The FSM SHALL move CLEAR->RUN on the edge that clears index 2**ADDRESS_WIDTH-1; ready SHALL equal (state==RUN).
REQ-021 In CLEAR, we3 and issue_valid SHALL be ignored.
REQ-022 In CLEAR, all rd slices, all busy bits and a0 SHALL read 0.
REQ-023 In RUN, when we3=1 and ad3!=0, mem[ad3] SHALL take wd3 at the clock edge.
REQ-024 Register 0 SHALL always read 0, SHALL never be written, and SHALL never be busy.
REQ-025 Each read port SHALL be combinational: rd[i]=mem[ad[i]].
REQ-026 If BYPASS=1, ready=1, we3=1, ad3==ad[i] and ad3!=0, rd[i] SHALL instead equal wd3 in the same cycle.
REQ-027 a0 SHALL equal mem[A0_INDEX] and SHALL NOT be bypassed.
REQ-028 The scoreboard SHALL hold one bit sb[r] per register.
REQ-029 sb[issue_rd] SHALL be set on an edge with issue_valid=1 and issue_rd!=0.
REQ-030 sb[ad3] SHALL be cleared on an edge with we3=1.
REQ-031 For a simultaneous issue and write to the same register, set SHALL win (new producer) while the data write still occurs.
REQ-032 busy[i] SHALL equal sb[ad[i]].
REQ-033 If BYPASS=1, busy[i] SHALL be forced to 0 when we3=1 and ad3==ad[i], unless that same cycle also issues to ad[i].
REQ-034 Multiple read ports addressing the same register SHALL return identical data and busy values.

Reset
REQ-035 While rst=1 at an edge: state SHALL become CLEAR, cnt 0, all sb bits 0, and ready 0 from the next cycle.
REQ-036 Register contents SHALL NOT be relied on until ready=1; the FSM, not rst, zeroes memory.
REQ-037 Asserting rst in RUN, or partway through CLEAR, SHALL restart the clear from index 0.
REQ-038 With defaults, ready SHALL rise exactly 32 edges after the first edge with rst=0.

Verification
REQ-039 Bench SHALL cover power-on: rst=1 for 2 cycles, then 0 -> ready=0 for 32 edges, then 1; every register and a0 read 0; a write during CLEAR is lost.
REQ-040 Bench SHALL cover write/read: we3=1, ad3=10, wd3=0xDEADBEEF -> same cycle rd[0] (ad=10)=0xDEADBEEF via bypass; next cycle a0=0xDEADBEEF; with BYPASS=0, rd[0] shows the old value until the edge.
REQ-041 Bench SHALL cover x0: we3=1, ad3=0, wd3=0xFFFFFFFF -> rd for ad=0 stays 0 in the same and following cycles; issue_rd=0 never sets busy.
REQ-042 Bench SHALL cover the scoreboard: issue x5, then busy[1]=1 for ad[1]=5; on the write cycle to x5 (we3=1, wd3=7), busy[1]=0 and rd[1]=7; afterwards sb[5]=0.
REQ-043 Bench SHALL cover a collision: issue_valid=1, issue_rd=6 together with we3=1, ad3=6, wd3=3 -> next cycle busy=1 for x6 and rd=3.
REQ-044 Bench SHALL cover mid-operation reset: write x3=9, set busy on x4, pulse rst for 1 cycle -> busy=0 immediately after, ready low for 32 edges, then x3 reads 0.

Source files
------------

// File: rtl/regfile_pipe.sv
// Multi-port register file with power-on clear FSM, write bypass and a
// per-register pending-write scoreboard.
module regfile_pipe #(
   parameter int ADDRESS_WIDTH = 5,
   parameter int DATA_WIDTH    = 32,
   parameter int READ_PORTS    = 2,
   parameter bit BYPASS        = 1'b1,
   parameter int A0_INDEX      = 10
) (
   input  logic                                clk,
   input  logic                                rst,
   input  logic [READ_PORTS*ADDRESS_WIDTH-1:0] ad,
   output logic [READ_PORTS*DATA_WIDTH-1:0]    rd,
   output logic [READ_PORTS-1:0]               busy,
   input  logic [ADDRESS_WIDTH-1:0]            ad3,
   input  logic [DATA_WIDTH-1:0]               wd3,
   input  logic                                we3,
   input  logic                                issue_valid,
   input  logic [ADDRESS_WIDTH-1:0]            issue_rd,
   output logic                                ready,
   output logic [DATA_WIDTH-1:0]               a0
);

   localparam int AW   = ADDRESS_WIDTH;
   localparam int DW   = DATA_WIDTH;
   localparam int NREG = 1 << AW;

   localparam logic [AW-1:0] LAST    = AW'(NREG - 1);
   localparam logic [AW-1:0] A0_ADDR = AW'(A0_INDEX);

   typedef enum logic {
      CLEAR,
      RUN
   } state_t;

   state_t          state;
   state_t          state_nx;
   logic [AW-1:0]   cnt;
   logic [AW-1:0]   cnt_nx;
   logic [NREG-1:0] sb;
   logic [NREG-1:0] sb_nx;

   logic            mem_we;
   logic [AW-1:0]   mem_wa;
   logic [DW-1:0]   mem_wd;
   logic [DW-1:0]   mem [NREG];

   always_ff @(posedge clk) begin
      if (rst) begin
         state <= CLEAR;
         cnt   <= '0;
         sb    <= '0;
      end else begin
         state <= state_nx;
         cnt   <= cnt_nx;
         sb    <= sb_nx;
      end
   end

   // Set is applied after clear so a same-edge reissue keeps the register busy.
   always_comb begin
      state_nx = state;
      cnt_nx   = cnt;
      sb_nx    = sb;
      mem_we   = 1'b0;
      mem_wa   = ad3;
      mem_wd   = wd3;
      ready    = 1'b0;
      unique case (state)
         CLEAR: begin
            mem_we = 1'b1;
            mem_wa = cnt;
            mem_wd = '0;
            cnt_nx = cnt + 1'b1;
            if (cnt == LAST) begin
               state_nx = RUN;
            end
         end
         RUN: begin
            ready  = 1'b1;
            mem_we = we3 && (ad3 != '0);
            if (we3) begin
               sb_nx[ad3] = 1'b0;
            end
            if (issue_valid && (issue_rd != '0)) begin
               sb_nx[issue_rd] = 1'b1;
            end
         end
         default: begin
            state_nx = CLEAR;
         end
      endcase
   end

   // Storage carries no reset; the CLEAR sweep is what zeroes it.
   always_ff @(posedge clk) begin
      if (mem_we) begin
         mem[mem_wa] <= mem_wd;
      end
   end

   for (genvar i = 0; i < READ_PORTS; i++) begin : g_rd
      logic [AW-1:0] a;
      logic          live;
      logic          hit;
      logic          reissue;

      assign a       = ad[i*AW +: AW];
      assign live    = ready && (a != '0);
      assign hit     = BYPASS && we3 && (ad3 == a);
      assign reissue = issue_valid && (issue_rd == a);

      assign rd[i*DW +: DW] = !live ? '0
                            : hit   ? wd3
                            :         mem[a];

      assign busy[i] = live && sb[a] && !(hit && !reissue);
   end

   assign a0 = (ready && (A0_ADDR != '0)) ? mem[A0_ADDR] : '0;

endmodule

// File: tb/tb_regfile_pipe.sv
// Scoreboard bench for regfile_pipe: stimulus queues expected values,
// a negedge monitor pops and compares them.
module tb_regfile_pipe;

   localparam int K_RD   = 0;
   localparam int K_BUSY = 1;
   localparam int K_A0   = 2;
   localparam int K_RDY  = 3;
   localparam int K_NBRD = 4;
   localparam int K_NBBZ = 5;

   typedef struct {
      string       name;
      int          kind;
      int          port;
      logic [31:0] exp;
   } exp_t;

   logic        clk;
   logic        rst;
   logic [9:0]  ad;
   logic [63:0] rd;
   logic [63:0] rd_nb;
   logic [1:0]  busy;
   logic [1:0]  busy_nb;
   logic [4:0]  ad3;
   logic [31:0] wd3;
   logic        we3;
   logic        issue_valid;
   logic [4:0]  issue_rd;
   logic        ready;
   logic        ready_nb;
   logic [31:0] a0;
   logic [31:0] a0_nb;

   exp_t        q[$];
   exp_t        e;
   logic [31:0] act;
   int          nvec = 0;
   int          nerr = 0;

   regfile_pipe dut (
      .clk(clk), .rst(rst), .ad(ad), .rd(rd), .busy(busy),
      .ad3(ad3), .wd3(wd3), .we3(we3),
      .issue_valid(issue_valid), .issue_rd(issue_rd),
      .ready(ready), .a0(a0)
   );

   regfile_pipe #(.BYPASS(1'b0)) dut_nb (
      .clk(clk), .rst(rst), .ad(ad), .rd(rd_nb), .busy(busy_nb),
      .ad3(ad3), .wd3(wd3), .we3(we3),
      .issue_valid(issue_valid), .issue_rd(issue_rd),
      .ready(ready_nb), .a0(a0_nb)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   function automatic logic [31:0] actual(input int k, input int p);
      case (k)
         K_RD:    return rd[p*32 +: 32];
         K_BUSY:  return {31'b0, busy[p]};
         K_A0:    return a0;
         K_RDY:   return {31'b0, ready};
         K_NBRD:  return rd_nb[p*32 +: 32];
         K_NBBZ:  return {31'b0, busy_nb[p]};
         default: return 32'hxxxx_xxxx;
      endcase
   endfunction

   always @(negedge clk) begin
      while (q.size() > 0) begin
         e   = q.pop_front();
         act = actual(e.kind, e.port);
         nvec++;
         if (act !== e.exp) begin
            nerr++;
            $display("FAIL %s: got %h want %h", e.name, act, e.exp);
         end
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      we3         = 1'b0;
      ad3         = '0;
      wd3         = '0;
      issue_valid = 1'b0;
      issue_rd    = '0;
   endtask

   task automatic rda(input int p0, input int p1);
      logic [4:0] x0;
      logic [4:0] x1;
      x0 = 5'(p0);
      x1 = 5'(p1);
      ad = {x1, x0};
   endtask

   task automatic wr(input int a, input logic [31:0] d);
      we3 = 1'b1;
      ad3 = 5'(a);
      wd3 = d;
   endtask

   task automatic iss(input int a);
      issue_valid = 1'b1;
      issue_rd    = 5'(a);
   endtask

   task automatic chk(input string n, input int k, input int p,
                      input logic [31:0] v);
      exp_t x;
      x.name = n;
      x.kind = k;
      x.port = p;
      x.exp  = v;
      q.push_back(x);
   endtask

   task automatic clear_wait(input string tag);
      for (int k = 1; k <= 32; k++) begin
         step();
         chk($sformatf("%s_ready_e%0d", tag, k), K_RDY, 0,
             (k == 32) ? 32'd1 : 32'd0);
      end
   endtask

   initial begin
      rst = 1'b1;
      ad  = '0;
      idle();
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b0;
      chk("por_ready_e0", K_RDY, 0, 0);
      for (int k = 1; k <= 32; k++) begin
         step();
         idle();
         if (k == 31) begin
            wr(7, 32'h0000_1234);
            iss(7);
            rda(7, 7);
            chk("clr_rd_gated", K_RD, 0, 0);
            chk("clr_busy_gated", K_BUSY, 0, 0);
            chk("clr_a0", K_A0, 0, 0);
         end
         chk($sformatf("por_ready_e%0d", k), K_RDY, 0,
             (k == 32) ? 32'd1 : 32'd0);
      end
      chk("clr_write_lost", K_RD, 0, 0);
      chk("clr_issue_lost", K_BUSY, 0, 0);

      for (int r = 0; r < 32; r++) begin
         step();
         rda(r, 31 - r);
         chk($sformatf("zero_p0_x%0d", r), K_RD, 0, 0);
         chk($sformatf("zero_p1_x%0d", 31 - r), K_RD, 1, 0);
         chk("zero_a0", K_A0, 0, 0);
      end

      step();
      wr(10, 32'hDEAD_BEEF);
      rda(10, 0);
      chk("wr_bypass", K_RD, 0, 32'hDEAD_BEEF);
      chk("wr_nb_old", K_NBRD, 0, 0);
      chk("wr_a0_nobyp", K_A0, 0, 0);
      step();
      idle();
      chk("wr_rd_after", K_RD, 0, 32'hDEAD_BEEF);
      chk("wr_nb_after", K_NBRD, 0, 32'hDEAD_BEEF);
      chk("wr_a0_after", K_A0, 0, 32'hDEAD_BEEF);

      step();
      wr(0, 32'hFFFF_FFFF);
      iss(0);
      rda(0, 0);
      chk("x0_rd_same", K_RD, 0, 0);
      chk("x0_rd1_same", K_RD, 1, 0);
      chk("x0_busy_same", K_BUSY, 0, 0);
      step();
      idle();
      chk("x0_rd_next", K_RD, 0, 0);
      chk("x0_busy_next", K_BUSY, 0, 0);
      chk("x0_busy1_next", K_BUSY, 1, 0);

      step();
      iss(5);
      rda(5, 5);
      chk("sb_issue_cycle", K_BUSY, 1, 0);
      step();
      idle();
      chk("sb_busy1", K_BUSY, 1, 1);
      chk("sb_busy0_same", K_BUSY, 0, 1);
      step();
      wr(5, 32'd7);
      chk("sb_wr_busy1", K_BUSY, 1, 0);
      chk("sb_wr_rd1", K_RD, 1, 32'd7);
      chk("sb_wr_busy0", K_BUSY, 0, 0);
      chk("sb_wr_rd0", K_RD, 0, 32'd7);
      chk("sb_nb_busy", K_NBBZ, 1, 1);
      chk("sb_nb_rd", K_NBRD, 1, 0);
      step();
      idle();
      chk("sb_after_busy", K_BUSY, 1, 0);
      chk("sb_after_rd", K_RD, 1, 32'd7);
      chk("sb_after_nb", K_NBBZ, 1, 0);

      step();
      iss(6);
      wr(6, 32'd3);
      rda(0, 6);
      chk("col_rd_same", K_RD, 1, 32'd3);
      chk("col_busy_same", K_BUSY, 1, 0);
      step();
      idle();
      chk("col_busy_next", K_BUSY, 1, 1);
      chk("col_rd_next", K_RD, 1, 32'd3);
      step();
      iss(6);
      wr(6, 32'd4);
      chk("reiss_busy", K_BUSY, 1, 1);
      chk("reiss_rd", K_RD, 1, 32'd4);
      step();
      idle();
      chk("reiss_busy_next", K_BUSY, 1, 1);
      chk("reiss_rd_next", K_RD, 1, 32'd4);
      step();
      wr(6, 32'd5);
      chk("ret_busy", K_BUSY, 1, 0);
      step();
      idle();
      chk("ret_busy_next", K_BUSY, 1, 0);
      chk("ret_rd_next", K_RD, 1, 32'd5);

      step();
      wr(3, 32'd9);
      iss(4);
      rda(3, 4);
      step();
      idle();
      chk("mr_rd_x3", K_RD, 0, 32'd9);
      chk("mr_busy_x4", K_BUSY, 1, 1);
      step();
      rst = 1'b1;
      chk("mr_ready_pre", K_RDY, 0, 1);
      step();
      rst = 1'b0;
      chk("mr_ready_e0", K_RDY, 0, 0);
      chk("mr_busy_clr", K_BUSY, 1, 0);
      chk("mr_rd_gated", K_RD, 0, 0);
      clear_wait("mr");
      chk("mr_x3_zero", K_RD, 0, 0);
      chk("mr_x4_idle", K_BUSY, 1, 0);
      chk("mr_a0_zero", K_A0, 0, 0);
      chk("mr_nb_x3", K_NBRD, 0, 0);

      @(negedge clk);
      #1;
      if (q.size() != 0) begin
         nerr++;
         $display("FAIL queue_drain: got %0d want 0", q.size());
      end
      $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
      $finish;
   end

endmodule
